// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: mult/div op encodings, FSM states, iteration count.
package mips_pkg;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  localparam logic [1:0] MD_IDLE  = 2'd0;
  localparam logic [1:0] MD_CALC  = 2'd1;
  localparam logic [1:0] MD_FIXUP = 2'd2;

  localparam int MD_ITER = 32;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit holding HI/LO. Shift-add multiply and restoring
// divide share one 64-bit accumulator; signs are stripped on entry and restored in FIXUP.
module mult_div_unit
  import mips_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  MDctrl,
  input  logic [31:0] Read_Data_1,
  input  logic [31:0] Alu_Src_Output,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        Busy,
  output logic        Done
);

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic [31:0] orig_q, orig_d;
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic        dz_q, dz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        sgn_op;
  logic [31:0] abs_a, abs_b;
  logic [32:0] madd;
  logic [32:0] rem_sh, rem_sub;
  logic        rem_ge;
  logic [63:0] prod;
  logic [31:0] quo, rem;

  assign sgn_op = ~MDctrl[0];
  assign abs_a  = (sgn_op && Read_Data_1[31])    ? -Read_Data_1    : Read_Data_1;
  assign abs_b  = (sgn_op && Alu_Src_Output[31]) ? -Alu_Src_Output : Alu_Src_Output;

  // Multiply: acc = {partial product, remaining multiplier bits}; carry rides in bit 32.
  assign madd = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opnd_q : 32'd0)};

  // Divide: acc = {partial remainder, dividend bits / quotient bits shifted in}.
  assign rem_sh  = acc_q[63:31];
  assign rem_sub = rem_sh - {1'b0, opnd_q};
  assign rem_ge  = (rem_sh >= {1'b0, opnd_q});

  assign prod = neg_res_q ? -acc_q : acc_q;
  assign quo  = neg_res_q ? -acc_q[31:0]  : acc_q[31:0];
  assign rem  = neg_rem_q ? -acc_q[63:32] : acc_q[63:32];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    orig_d    = orig_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (Start) begin
          case (MDctrl)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              state_d   = MD_CALC;
              cnt_d     = 6'd0;
              busy_d    = 1'b1;
              is_div_d  = MDctrl[1];
              acc_d     = MDctrl[1] ? {32'd0, abs_a} : {32'd0, abs_b};
              opnd_d    = MDctrl[1] ? abs_b : abs_a;
              orig_d    = Read_Data_1;
              neg_res_d = sgn_op & (Read_Data_1[31] ^ Alu_Src_Output[31]);
              neg_rem_d = sgn_op & Read_Data_1[31];
              dz_d      = (Alu_Src_Output == 32'd0);
            end
            MD_MTHI: hi_d = Read_Data_1;
            MD_MTLO: lo_d = Read_Data_1;
            default: ;
          endcase
        end
      end
      MD_CALC: begin
        if (is_div_q)
          acc_d = rem_ge ? {rem_sub[31:0], acc_q[30:0], 1'b1}
                         : {rem_sh[31:0],  acc_q[30:0], 1'b0};
        else
          acc_d = {madd, acc_q[31:1]};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(MD_ITER - 1))
          state_d = MD_FIXUP;
      end
      MD_FIXUP: begin
        state_d = MD_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (!is_div_q) begin
          hi_d = prod[63:32];
          lo_d = prod[31:0];
        end else if (dz_q) begin
          hi_d = orig_q;
          lo_d = 32'hFFFF_FFFF;
        end else begin
          hi_d = rem;
          lo_d = quo;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= MD_IDLE;
      cnt_q     <= 6'd0;
      acc_q     <= 64'd0;
      opnd_q    <= 32'd0;
      orig_q    <= 32'd0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      orig_q    <= orig_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign Hi   = hi_q;
  assign Lo   = lo_q;
  assign Busy = busy_q;
  assign Done = done_q;

  // Illegal ops are dropped by the FSM; flag them loudly in simulation.
  a_illegal_op: assert property (@(posedge Clk) disable iff (Reset)
    !(Start && state_q == MD_IDLE && MDctrl[2:1] == 2'b11))
    else $error("mult_div_unit: illegal MDctrl %b with Start", MDctrl);

endmodule
